q2_mem_port: RTL and testbench

- Memory-side responder for the Q2 slice buses.
- Samples the address from abus and services read/write strobes from the control sequencer with a fixed-latency handshake.
- Drives dbus only during the read-data window; captures dbus on writes.
- Also services front-panel examine/deposit while the CPU is halted.

---
 rtl/q2_mem_port_if.sv | 40 ++++
 rtl/q2_mem_port.sv | 153 +++++++++++++++
 tb/tb_q2_mem_port.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q2_mem_port_if.sv
// rtl/q2_mem_port_if.sv - Q2 memory port request/response and front-panel bundle
//
// Purpose: carries the CPU-side request/response signals and the front-panel
// signals between a requester (master) and the Q2 memory port (slave).
// Signals:
//   abus     address bus from the slice X/P tri-states
//   rd, wr   read / write request levels, sampled on clk
//   ack      one-cycle pulse: read data valid / write committed
//   busy     high while a request is in progress
//   rdata_oe high while the port drives dbus
//   halt     CPU halted, enables front-panel actions
//   exam,dep front-panel examine / deposit levels (rising edge acts)
//   sw       front-panel switch word
//   lights   last word read or examined
// The tri-state data bus dbus stays a plain inout on the port module.
interface q2_mem_port_if #(
   parameter int WIDTH = 12
);
   logic [WIDTH-1:0] abus;
   logic             rd;
   logic             wr;
   logic             ack;
   logic             busy;
   logic             rdata_oe;
   logic             halt;
   logic             exam;
   logic             dep;
   logic [WIDTH-1:0] sw;
   logic [WIDTH-1:0] lights;

   modport master (
      output abus, rd, wr, halt, exam, dep, sw,
      input  ack, busy, rdata_oe, lights
   );

   modport slave (
      input  abus, rd, wr, halt, exam, dep, sw,
      output ack, busy, rdata_oe, lights
   );
endinterface

// File: rtl/q2_mem_port.sv
// rtl/q2_mem_port.sv - Q2 slice-bus memory responder with front-panel examine/deposit
//
// Purpose: word memory answering rd/wr requests from the control sequencer with a
// fixed-latency handshake, and servicing front-panel examine/deposit while halted.
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   asynchronous active-high reset (memory contents are kept)
//   dbus  tri-state data bus, driven only in the read-data cycle
//   bus   q2_mem_port_if.slave: abus, rd, wr, ack, busy, rdata_oe, halt,
//         exam, dep, sw, lights
// Parameters: WIDTH (bus width), DEPTH (words, power of two, address wraps),
//             RD_LAT (cycles in the read wait phase, >= 1).
// Build option: Q2_MEM_PANEL_AUTOINC_EN - panel address steps by one after each deposit.
module q2_mem_port #(
   parameter int WIDTH  = 12,
   parameter int DEPTH  = 4096,
   parameter int RD_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   inout  wire  [WIDTH-1:0] dbus,
   q2_mem_port_if.slave     bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_DONE, PANEL} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    raddr;
   logic [AW-1:0]    paddr;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rdata;
   logic             exam_q;
   logic             dep_q;
   logic             ack_r;
   logic             busy_r;
   logic             oe_r;
   logic [WIDTH-1:0] lights_r;

   logic             exam_rise;
   logic             dep_rise;
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;

   // Upper address bits are dropped: DEPTH is a power of two, so this is the modulo wrap.
   wire  [AW-1:0]    a_idx  = bus.abus[AW-1:0];
   wire  [AW-1:0]    sw_idx = bus.sw[AW-1:0];

   always_comb begin
      exam_rise = bus.exam & ~exam_q;
      dep_rise  = bus.dep & ~dep_q;
      mem_we    = 1'b0;
      mem_waddr = a_idx;
      mem_wdata = dbus;
      // Writes are decided on the IDLE edge; rst blocks them so a held wr
      // cannot commit while the port is being reset.
      if (!rst && state == IDLE && !bus.rd) begin
         if (bus.wr) begin
            mem_we = 1'b1;
         end else if (bus.halt && !exam_rise && dep_rise) begin
            mem_we    = 1'b1;
            mem_waddr = paddr;
            mem_wdata = bus.sw;
         end
      end
   end

   // Storage has no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         raddr    <= '0;
         paddr    <= '0;
         rdata    <= '0;
         exam_q   <= 1'b0;
         dep_q    <= 1'b0;
         ack_r    <= 1'b0;
         busy_r   <= 1'b0;
         oe_r     <= 1'b0;
         lights_r <= '0;
      end else begin
         // Edge detectors track every cycle, so panel edges seen outside an
         // accepting IDLE cycle are simply lost.
         exam_q <= bus.exam;
         dep_q  <= bus.dep;
         ack_r  <= 1'b0;
         oe_r   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.rd) begin
                  raddr  <= a_idx;
                  cnt    <= CW'(RD_LAT - 1);
                  busy_r <= 1'b1;
                  state  <= RD_WAIT;
               end else if (bus.wr) begin
                  ack_r  <= 1'b1;
                  busy_r <= 1'b1;
                  state  <= WR_DONE;
               end else if (bus.halt && exam_rise) begin
                  paddr    <= sw_idx;
                  lights_r <= mem[sw_idx];
                  busy_r   <= 1'b1;
                  state    <= PANEL;
               end else if (bus.halt && dep_rise) begin
                  lights_r <= bus.sw;
                  busy_r   <= 1'b1;
                  state    <= PANEL;
`ifdef Q2_MEM_PANEL_AUTOINC_EN
                  paddr    <= paddr + 1'b1;
`else
                  paddr    <= paddr;
`endif
               end
            end
            RD_WAIT: begin
               if (cnt == '0) begin
                  rdata    <= mem[raddr];
                  lights_r <= mem[raddr];
                  ack_r    <= 1'b1;
                  oe_r     <= 1'b1;
                  state    <= RD_DRIVE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RD_DRIVE, WR_DONE, PANEL: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign dbus         = oe_r ? rdata : 'z;
   assign bus.ack      = ack_r;
   assign bus.busy     = busy_r;
   assign bus.rdata_oe = oe_r;
   assign bus.lights   = lights_r;
endmodule

// File: tb/tb_q2_mem_port.sv
// tb/tb_q2_mem_port.sv - bench for q2_mem_port against a cycle-indexed behavioural model
module tb_q2_mem_port;
   localparam int W      = 12;
   localparam int DEPTH  = 16;
   localparam int RD_LAT = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] tb_dout = '0;
   wire  [W-1:0] dbus;

   q2_mem_port_if #(.WIDTH(W)) bus ();

   q2_mem_port #(.WIDTH(W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk  (clk),
      .rst  (rst),
      .dbus (dbus),
      .bus  (bus)
   );

   // The requester releases dbus whenever the port is driving it.
   assign dbus = bus.rdata_oe ? 'z : tb_dout;

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Behavioural model: edge index cyc; a request accepted on edge k is
   // described by the cycles (after edge n) in which busy/ack/oe hold.
   logic [W-1:0] mmem [DEPTH];
   int           cyc = 0;
   int           accept_from = 0;
   int           busy_until = -1;
   int           ack_cyc = -1;
   int           oe_cyc = -1;
   int           pend_cyc = -1;
   logic [W-1:0] rd_val = '0;
   logic [W-1:0] exp_lights = '0;
   int           m_paddr = 0;
   logic         prev_exam = 1'b0;
   logic         prev_dep = 1'b0;
   logic [W-1:0] last_rd = '0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            accept_from = 0;
            busy_until  = -1;
            ack_cyc     = -1;
            oe_cyc      = -1;
            pend_cyc    = -1;
            exp_lights  = '0;
            m_paddr     = 0;
            prev_exam   = 1'b0;
            prev_dep    = 1'b0;
         end else begin
            logic er, dr;
            int   a;
            cyc++;
            er = bus.exam && !prev_exam;
            dr = bus.dep && !prev_dep;
            prev_exam = bus.exam;
            prev_dep  = bus.dep;
            a = int'(bus.abus) % DEPTH;
            if (cyc >= accept_from) begin
               if (bus.rd) begin
                  rd_val      = mmem[a];
                  busy_until  = cyc + RD_LAT;
                  ack_cyc     = cyc + RD_LAT;
                  oe_cyc      = cyc + RD_LAT;
                  pend_cyc    = cyc + RD_LAT;
                  accept_from = cyc + RD_LAT + 2;
               end else if (bus.wr) begin
                  mmem[a]     = tb_dout;
                  busy_until  = cyc;
                  ack_cyc     = cyc;
                  accept_from = cyc + 2;
               end else if (bus.halt && er) begin
                  m_paddr     = int'(bus.sw) % DEPTH;
                  exp_lights  = mmem[m_paddr];
                  busy_until  = cyc;
                  accept_from = cyc + 2;
               end else if (bus.halt && dr) begin
                  mmem[m_paddr] = bus.sw;
                  exp_lights    = bus.sw;
`ifdef Q2_MEM_PANEL_AUTOINC_EN
                  m_paddr       = (m_paddr + 1) % DEPTH;
`endif
                  busy_until    = cyc;
                  accept_from   = cyc + 2;
               end
            end
            if (cyc == pend_cyc) exp_lights = rd_val;
         end
      end
   end

   // Compare process: every cycle out of reset, at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("busy", 32'(bus.busy), 32'(cyc <= busy_until));
            chk("ack", 32'(bus.ack), 32'(cyc == ack_cyc));
            chk("rdata_oe", 32'(bus.rdata_oe), 32'(cyc == oe_cyc));
            chk("lights", 32'(bus.lights), 32'(exp_lights));
            if (cyc == oe_cyc) chk("dbus_read", 32'(dbus), 32'(rd_val));
            if (bus.ack && bus.rdata_oe) last_rd = dbus;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d);
      bus.abus = a;
      tb_dout  = d;
      bus.wr   = 1'b1;
      step(1);
      bus.wr   = 1'b0;
      step(2);
   endtask

   task automatic do_read(input logic [W-1:0] a);
      bus.abus = a;
      bus.rd   = 1'b1;
      step(1);
      bus.rd   = 1'b0;
      step(RD_LAT + 2);
   endtask

   task automatic pulse_exam(input logic [W-1:0] s);
      bus.sw   = s;
      bus.exam = 1'b1;
      step(1);
      bus.exam = 1'b0;
      step(2);
   endtask

   task automatic pulse_dep(input logic [W-1:0] s);
      bus.sw  = s;
      bus.dep = 1'b1;
      step(1);
      bus.dep = 1'b0;
      step(2);
   endtask

   initial begin
      logic got;
      bus.abus = '0;
      bus.rd   = 1'b0;
      bus.wr   = 1'b0;
      bus.halt = 1'b0;
      bus.exam = 1'b0;
      bus.dep  = 1'b0;
      bus.sw   = '0;
      #1;
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_ack", 32'(bus.ack), 32'd0);
      chk("reset_oe", 32'(bus.rdata_oe), 32'd0);
      chk("reset_lights", 32'(bus.lights), 32'd0);
      step(2);
      rst = 1'b0;
      step(1);

      // Fill every word, using random upper address bits to exercise the wrap.
      for (int i = 0; i < DEPTH; i++) begin
         do_write(W'(i + DEPTH * $urandom_range(0, 255)), W'($urandom));
      end

      do_write(12'h005, 12'hA5C);
      chk("model_mem5", 32'(mmem[5]), 32'h0A5C);
      do_read(12'h005);
      chk("read_005", 32'(last_rd), 32'h0A5C);
      chk("lights_005", 32'(bus.lights), 32'h0A5C);

      do_write(12'h013, 12'h7FF);
      do_read(12'h003);
      chk("wrap_read", 32'(last_rd), 32'h07FF);

      // rd and wr together: read first, held wr lands on the next IDLE cycle.
      do_write(12'h000, 12'h5A5);
      bus.abus = 12'h010;
      tb_dout  = 12'h3C3;
      bus.rd   = 1'b1;
      bus.wr   = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.ack) begin
            got = 1'b1;
            break;
         end
      end
      chk("coll_ack_seen", 32'(got), 32'd1);
      #1;
      bus.rd = 1'b0;
      step(3);
      bus.wr = 1'b0;
      step(2);
      chk("coll_read_first", 32'(last_rd), 32'h05A5);
      do_read(12'h000);
      chk("coll_write_after", 32'(last_rd), 32'h03C3);

      // Reset in the middle of the read wait phase.
      bus.abus = 12'h003;
      bus.rd   = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      chk("rst_mid_oe", 32'(bus.rdata_oe), 32'd0);
      chk("rst_mid_ack", 32'(bus.ack), 32'd0);
      chk("rst_mid_lights", 32'(bus.lights), 32'd0);
      bus.rd = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      step(RD_LAT + 3);

      // Front panel.
      bus.halt = 1'b1;
      pulse_exam(12'h020);
      chk("exam_lights", 32'(bus.lights), 32'h03C3);
      pulse_dep(12'h111);
      pulse_dep(12'h222);
      bus.halt = 1'b0;
`ifdef Q2_MEM_PANEL_AUTOINC_EN
      do_read(12'h000);
      chk("dep_word0", 32'(last_rd), 32'h0111);
      do_read(12'h001);
      chk("dep_word1", 32'(last_rd), 32'h0222);
`else
      do_read(12'h000);
      chk("dep_word0", 32'(last_rd), 32'h0222);
`endif
      // Deposit edge with halt low must do nothing.
      pulse_dep(12'hFFF);
      chk("gated_lights", 32'(bus.lights), 32'h0222);
      chk("gated_busy", 32'(bus.busy), 32'd0);
      do_read(12'h000);
`ifdef Q2_MEM_PANEL_AUTOINC_EN
      chk("gated_word0", 32'(last_rd), 32'h0111);
`else
      chk("gated_word0", 32'(last_rd), 32'h0222);
`endif

      // Random traffic on all request and panel inputs.
      for (int i = 0; i < 600; i++) begin
         bus.rd   = ($urandom_range(0, 4) == 0);
         bus.wr   = ($urandom_range(0, 4) == 0);
         bus.halt = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) bus.exam = ~bus.exam;
         if ($urandom_range(0, 2) == 0) bus.dep = ~bus.dep;
         bus.abus = W'($urandom);
         bus.sw   = W'($urandom);
         tb_dout  = W'($urandom);
         step(1);
      end
      bus.rd   = 1'b0;
      bus.wr   = 1'b0;
      bus.exam = 1'b0;
      bus.dep  = 1'b0;
      step(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
